// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, default frame geometry,
// mid-bit sample positions and the 2-of-3 majority helper.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        START   = 3'd1,
        DATA    = 3'd2,
        STOP    = 3'd3,
        WAIT_HI = 3'd4
    } state_t;

    // Defaults shared by the baud generator, transmitter and receiver.
    localparam int DBIT_DEF = 8;
    localparam int OS_DEF   = 16;

    // First and last of the three mid-bit sample positions.
    localparam int MID_LO = OS_DEF / 2 - 1;
    localparam int MID_HI = OS_DEF / 2 + 1;

    // Same positions for a non-default oversampling ratio.
    function automatic int mid_lo(input int os);
        return os / 2 - 1;
    endfunction

    function automatic int mid_hi(input int os);
        return os / 2 + 1;
    endfunction

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Input synchroniser for the asynchronous rx line plus the three-sample
// register that feeds the majority vote.
module uart_rx_sync
    import uart_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic rx,
    input  logic sample_en,
    output logic rx_s,
    output logic vote_now,
    output logic vote
);

    logic [SYNC_STAGES-1:0] sync_reg;
    logic [2:0]             samp_reg;

    // Flop chain; resets to the idle (high) line level so no false start bit.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_reg <= '1;
        end else begin
            sync_reg <= {sync_reg[SYNC_STAGES-2:0], rx};
        end
    end

    assign rx_s = sync_reg[SYNC_STAGES-1];

    // Capture rx_s on each of the three mid-bit sample ticks.
    always_ff @(posedge clk) begin
        if (reset) begin
            samp_reg <= 3'b111;
        end else if (sample_en) begin
            samp_reg <= {samp_reg[1:0], rx_s};
        end
    end

    // On the last sample tick the third sample is still rx_s itself, so
    // START/STOP decide from two stored samples plus the live one.
    assign vote_now = maj3(samp_reg[1], samp_reg[0], rx_s);
    // After the window all three samples are stored.
    assign vote     = maj3(samp_reg[2], samp_reg[1], samp_reg[0]);

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver driven by an oversampled baud tick. Writes good bytes
// into the RX FIFO and flags framing errors, breaks and overruns.
module uart_rx
    import uart_pkg::*;
#(
    parameter int DBIT        = DBIT_DEF,
    parameter int OS          = OS_DEF,
    parameter int SYNC_STAGES = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            b_tick,
    input  logic            rx,
    input  logic            rx_full,
    input  logic            err_clr,
    output logic [DBIT-1:0] rx_data,
    output logic            rx_valid,
    output logic            frame_err,
    output logic            brk,
    output logic            overrun,
    output logic            busy
);

    localparam int CW = $clog2(OS);
    localparam int NW = (DBIT > 1) ? $clog2(DBIT) : 1;

    localparam logic [CW-1:0] S_LO   = CW'(mid_lo(OS));
    localparam logic [CW-1:0] S_HI   = CW'(mid_hi(OS));
    localparam logic [CW-1:0] S_END  = CW'(OS - 1);
    localparam logic [NW-1:0] N_LAST = NW'(DBIT - 1);

    state_t          state_reg, state_next;
    logic [CW-1:0]   s_cnt_reg, s_cnt_next;
    logic [NW-1:0]   n_reg, n_next;
    logic [DBIT-1:0] shreg_reg, shreg_next;
    logic [DBIT-1:0] data_reg, data_next;
    logic            valid_reg, valid_next;
    logic            ferr_reg, ferr_next;
    logic            brk_reg, brk_next;
    logic            ovr_reg, ovr_next;
    logic            ovr_set;

    logic            rx_s;
    logic            vote_now;
    logic            vote;
    logic            sample_en;

    assign sample_en = b_tick && (s_cnt_reg >= S_LO) && (s_cnt_reg <= S_HI);

    uart_rx_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk       (clk),
        .reset     (reset),
        .rx        (rx),
        .sample_en (sample_en),
        .rx_s      (rx_s),
        .vote_now  (vote_now),
        .vote      (vote)
    );

    // State, counters, shift register and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
            s_cnt_reg <= '0;
            n_reg     <= '0;
            shreg_reg <= '0;
            data_reg  <= '0;
            valid_reg <= 1'b0;
            ferr_reg  <= 1'b0;
            brk_reg   <= 1'b0;
            ovr_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            s_cnt_reg <= s_cnt_next;
            n_reg     <= n_next;
            shreg_reg <= shreg_next;
            data_reg  <= data_next;
            valid_reg <= valid_next;
            ferr_reg  <= ferr_next;
            brk_reg   <= brk_next;
            ovr_reg   <= ovr_next;
        end
    end

    // Frame FSM; everything advances only on b_tick, pulses default low.
    always_comb begin
        state_next = state_reg;
        s_cnt_next = s_cnt_reg;
        n_next     = n_reg;
        shreg_next = shreg_reg;
        data_next  = data_reg;
        valid_next = 1'b0;
        ferr_next  = 1'b0;
        brk_next   = 1'b0;
        ovr_set    = 1'b0;

        if (b_tick) begin
            s_cnt_next = s_cnt_reg + 1'b1;
            case (state_reg)
                IDLE: begin
                    s_cnt_next = '0;
                    if (!rx_s) begin
                        state_next = START;
                    end
                end
                START: begin
                    if (s_cnt_reg == S_HI && vote_now) begin
                        // Start bit did not hold low through its centre.
                        state_next = IDLE;
                        s_cnt_next = '0;
                    end else if (s_cnt_reg == S_END) begin
                        state_next = DATA;
                        s_cnt_next = '0;
                        n_next     = '0;
                    end
                end
                DATA: begin
                    if (s_cnt_reg == S_END) begin
                        s_cnt_next = '0;
                        shreg_next = {vote, shreg_reg[DBIT-1:1]};
                        n_next     = n_reg + 1'b1;
                        if (n_reg == N_LAST) begin
                            state_next = STOP;
                        end
                    end
                end
                STOP: begin
                    // Decide at the stop-bit centre so back-to-back frames
                    // keep half a bit of slack.
                    if (s_cnt_reg == S_HI) begin
                        s_cnt_next = '0;
                        if (vote_now) begin
                            state_next = IDLE;
                            if (rx_full) begin
                                ovr_set = 1'b1;
                            end else begin
                                data_next  = shreg_reg;
                                valid_next = 1'b1;
                            end
                        end else begin
                            ferr_next  = 1'b1;
                            brk_next   = (shreg_reg == '0);
                            state_next = WAIT_HI;
                        end
                    end
                end
                WAIT_HI: begin
                    // Stay out of IDLE until the line recovers, otherwise a
                    // held-low line would restart a frame every bit time.
                    s_cnt_next = '0;
                    if (rx_s) begin
                        state_next = IDLE;
                    end
                end
                default: begin
                    state_next = IDLE;
                    s_cnt_next = '0;
                end
            endcase
        end

        // Sticky overrun: a new drop outranks a simultaneous clear.
        ovr_next = ovr_set | (ovr_reg & ~err_clr);
    end

    assign rx_data   = data_reg;
    assign rx_valid  = valid_reg;
    assign frame_err = ferr_reg;
    assign brk       = brk_reg;
    assign overrun   = ovr_reg;
    assign busy      = (state_reg != IDLE);

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
UART receiver. It is the serial-in counterpart of the board's UART transmitter and shares the same oversampled baud tick.
It deserialises 8N1 frames from the uart_rx pin and writes each good byte into the RX byte FIFO. It also flags framing errors, breaks and FIFO overruns for the host-command path on clk100M.

Parameters:
DBIT, 8, data bits per frame; LSB first; no parity.
OS, 16, b_tick pulses per bit time. Must be even and at least 8.
SYNC_STAGES, 2, number of synchroniser flops on rx; minimum 2.

Ports:
clk  in  1  system clock (clk100M domain)
reset  in  1  synchronous active-high reset
b_tick  in  1  one-clk pulse at OS x baud, from the baud generator
rx  in  1  asynchronous serial line; idles high
rx_full  in  1  full flag of the downstream FIFO
err_clr  in  1  one-clk pulse that clears overrun
rx_data  out  DBIT  last good byte; held until the next good byte
rx_valid  out  1  one-clk write strobe to the FIFO
frame_err  out  1  one-clk pulse on a bad stop bit
brk  out  1  one-clk pulse on a break (coincides with frame_err)
overrun  out  1  sticky flag: byte dropped because FIFO full
busy  out  1  high whenever state is not IDLE

Behaviour:
- Interface: one clock, clk. Reset is synchronous and active-high. On reset: state=IDLE, all counters=0, sync flops=1, rx_data=0, rx_valid/frame_err/brk/overrun/busy=0. Reset mid-frame abandons the frame; no output pulse is emitted for it.
- Timing base: all counters and state transitions act only on clk cycles where b_tick=1. rx_s is the SYNC_STAGES-delayed copy of rx.
- Bit-window counter s_cnt runs 0..OS-1 and is reset to 0 on every state entry. In each window, rx_s is sampled at s_cnt = OS/2-1, OS/2 and OS/2+1. The bit value v is the 2-of-3 majority of those samples.
- States:
  - IDLE: on a tick with rx_s=0 → START, s_cnt=0.
  - START: on the tick at s_cnt=OS/2+1, if v=1 it is a glitch → IDLE with no pulse. Otherwise continue; at s_cnt=OS-1 → DATA with bit index n=0.
  - DATA: at s_cnt=OS-1, shift v into the MSB of the shift register (LSB first) and increment n. After bit DBIT-1 → STOP.
  - STOP: on the tick at s_cnt=OS/2+1, decide immediately (no wait for end of stop bit):
    - v=1 and rx_full=0: rx_data<=shift register; rx_valid=1 for the next clk; → IDLE.
    - v=1 and rx_full=1: byte dropped; rx_data unchanged; overrun<=1; → IDLE.
    - v=0: frame_err pulse. brk also pulses if the shift register is all zeros. → WAIT_HI.
  - WAIT_HI: on a tick with rx_s=1 → IDLE.
- Latency: count the tick on which IDLE sees rx_s=0 as tick 0. The decision is made on tick OS*(DBIT+1)+OS/2+2 (154 for 8/16). The output pulse appears in the clk cycle after that tick.
- overrun: set as above. Cleared by err_clr. If a set and err_clr occur in the same cycle, set wins.
- Outputs are registered. There is no combinational path from rx to any output.
- A b_tick asserted every clk (OS x baud = clk) must work with identical behaviour.

Decomposition:
- Shared package uart_pkg holds:
  - the state enum (IDLE, START, DATA, STOP, WAIT_HI);
  - the default OS and DBIT constants, so the baud generator and transmitter use the same values;
  - localparams MID_LO=OS/2-1 and MID_HI=OS/2+1.
- One sub-module, uart_rx_sync: the SYNC_STAGES flop chain with reset value 1 and the majority-vote sample register.
- The FSM, counters and shift register stay in uart_rx.

Test Plan:
1. Drive 0x55, a clean frame at OS-tick bit period → exactly one rx_valid, rx_data=0x55, on the clk after tick 154. busy falls on the same clk.
2. Hold rx low for 4 ticks, then high → no rx_valid or frame_err; state returns to IDLE and busy drops.
3. Send 0xA3 with stop bit=0, then 0x3C clean → first frame gives frame_err=1 and brk=0, with no rx_valid and rx_data unchanged. Second frame gives rx_valid with rx_data=0x3C.
4. Hold rx low for 12 bit times, then release → exactly one frame_err and one brk, in the same cycle. No further pulses until rx goes high. The next clean frame 0x81 is received correctly.
5. Hold rx_full=1 while sending 0x7E → no rx_valid, rx_data keeps its previous value, overrun=1. Pulse err_clr → overrun=0. Assert err_clr in the same cycle as a new overrun → overrun stays 1.
6. Send 0x0F with a 1-tick inverted spike at s_cnt=OS/2 of bit 2 → majority vote rejects the spike and rx_data=0x0F. Then assert reset at bit 4 of a following frame → no pulse, outputs cleared, and the next frame 0xC6 is received correctly.
